// File: rtl/contador_bcd_param.sv
// Parameterised up/down BCD counter with free-running tick prescaler and a
// multiplexed active-low seven-segment scan driver.
module contador_bcd_param #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned TICK_DIV   = 50000000,
    parameter int unsigned SCAN_DIV   = 50000
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ena_i,
    input  logic                    up_dn_i,
    input  logic                    load_i,
    input  logic [4*NUM_DIGITS-1:0] load_data_i,
    output logic [4*NUM_DIGITS-1:0] count_o,
    output logic                    tick_o,
    output logic                    tc_o,
    output logic [NUM_DIGITS-1:0]   seg_sel_o,
    output logic [6:0]              seg_data_o
);

    localparam int unsigned W      = 4 * NUM_DIGITS;
    localparam int unsigned PrescW = $clog2(TICK_DIV);
    localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);
    localparam logic [ScanW-1:0]  ScanMax  = ScanW'(SCAN_DIV - 1);
    localparam logic [IdxW-1:0]   IdxMax   = IdxW'(NUM_DIGITS - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [PrescW-1:0]   presc_q, presc_d;
    logic                tick_q, tick_d;
    logic [W-1:0]        count_q, count_d;
    logic                tc_q, tc_d;
    logic [ScanW-1:0]    scan_q, scan_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;
    logic [6:0]          seg_data_q, seg_data_d;

    logic [W-1:0]        load_clean;
    logic [W-1:0]        step_val;
    logic                carry;

    always_comb begin
        presc_d = (presc_q == PrescMax) ? '0 : presc_q + 1'b1;
        tick_d  = (presc_q == PrescMax);
    end

    // Ripple carry/borrow across all digits; carry surviving the top digit marks a wrap.
    always_comb begin
        load_clean = '0;
        step_val   = count_q;
        carry      = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_clean[4*i +: 4] = (load_data_i[4*i +: 4] > 4'd9) ? 4'd0 : load_data_i[4*i +: 4];
            if (carry) begin
                if (up_dn_i) begin
                    if (count_q[4*i +: 4] == 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (count_q[4*i +: 4] == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end

        count_d = count_q;
        tc_d    = 1'b0;
        if (load_i) begin
            count_d = load_clean;
        end else if (tick_q && ena_i) begin
            count_d = step_val;
            tc_d    = carry;
        end
    end

    // Segment outputs are built from next-state index and count so they line up with count_o.
    always_comb begin
        scan_d = (scan_q == ScanMax) ? '0 : scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == ScanMax) begin
            idx_d = (idx_q == IdxMax) ? '0 : idx_q + 1'b1;
        end
        seg_sel_d  = ~(NUM_DIGITS'(1) << idx_d);
        seg_data_d = seg_decode(count_d[4*idx_d +: 4]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            count_q    <= '0;
            tc_q       <= 1'b0;
            scan_q     <= '0;
            idx_q      <= '0;
            seg_sel_q  <= ~NUM_DIGITS'(1);
            seg_data_q <= 7'b1000000;
        end else begin
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            count_q    <= count_d;
            tc_q       <= tc_d;
            scan_q     <= scan_d;
            idx_q      <= idx_d;
            seg_sel_q  <= seg_sel_d;
            seg_data_q <= seg_data_d;
        end
    end

    assign count_o    = count_q;
    assign tick_o     = tick_q;
    assign tc_o       = tc_q;
    assign seg_sel_o  = seg_sel_q;
    assign seg_data_o = seg_data_q;

endmodule

// File: tb/tb_contador_bcd_param.sv
// Directed bench for contador_bcd_param with TICK_DIV=4, SCAN_DIV=2, NUM_DIGITS=4.
module tb_contador_bcd_param;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        up_dn;
    logic        load;
    logic [15:0] load_data;
    logic [15:0] count;
    logic        tick;
    logic        tc;
    logic [3:0]  seg_sel;
    logic [6:0]  seg_data;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int n_ticks  = 0;

    logic [3:0] sel_tab [4];
    logic [6:0] seg_tab [4];

    contador_bcd_param #(
        .NUM_DIGITS(4),
        .TICK_DIV  (4),
        .SCAN_DIV  (2)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ena_i      (ena),
        .up_dn_i    (up_dn),
        .load_i     (load),
        .load_data_i(load_data),
        .count_o    (count),
        .tick_o     (tick),
        .tc_o       (tc),
        .seg_sel_o  (seg_sel),
        .seg_data_o (seg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    initial begin
        sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

        rst = 1'b1; ena = 1'b1; up_dn = 1'b1; load = 1'b1; load_data = 16'h4321;
        repeat (3) step();
        check("rst_count", count, 32'h0000);
        check("rst_tc", tc, 0);
        check("rst_tick", tick, 0);
        check("rst_sel", seg_sel, 32'b1110);
        check("rst_seg", seg_data, 32'b1000000);

        rst = 1'b0; load = 1'b0; cyc = 0;
        for (int c = 1; c <= 41; c++) begin
            step();
            check("tick_period", tick, 32'((c % 4) == 0));
        end
        check("count_10_ticks", count, 32'h0010);

        ena = 1'b0;
        for (int c = 42; c <= 61; c++) begin
            step();
            if (tick) n_ticks++;
        end
        check("hold_count", count, 32'h0010);
        check("hold_ticks", n_ticks, 5);

        load = 1'b1; load_data = 16'h9999;
        step();
        check("load_9999", count, 32'h9999);
        load = 1'b0; ena = 1'b1; up_dn = 1'b1;
        run_to(64);
        check("pre_wrap_count", count, 32'h9999);
        check("pre_wrap_tick", tick, 1);
        step();
        check("wrap_up_count", count, 32'h0000);
        check("wrap_up_tc", tc, 1);
        step();
        check("wrap_up_tc_off", tc, 0);
        run_to(69);
        check("up_0001", count, 32'h0001);
        check("up_0001_tc", tc, 0);

        load = 1'b1; load_data = 16'h0000; up_dn = 1'b0;
        step();
        check("load_0000", count, 32'h0000);
        load = 1'b0;
        run_to(73);
        check("wrap_dn_count", count, 32'h9999);
        check("wrap_dn_tc", tc, 1);
        step();
        check("wrap_dn_tc_off", tc, 0);
        run_to(77);
        check("dn_9998", count, 32'h9998);

        run_to(80);
        check("tick_before_load", tick, 1);
        load = 1'b1; load_data = 16'h12A4;
        step();
        check("load_prio_count", count, 32'h1204);
        check("load_prio_tc", tc, 0);
        load = 1'b0;
        run_to(85);
        check("dn_1203", count, 32'h1203);
        up_dn = 1'b1;
        run_to(89);
        check("dir_change_1204", count, 32'h1204);

        load = 1'b1; load_data = 16'h1234; ena = 1'b0;
        step();
        check("load_1234", count, 32'h1234);
        check("seg_follow_sel", seg_sel, 32'b1101);
        check("seg_follow_data", seg_data, 32'b0110000);
        load = 1'b0;
        run_to(95);
        for (int k = 0; k < 8; k++) begin
            step();
            check("scan_sel", seg_sel, 32'(sel_tab[k/2]));
            check("scan_seg", seg_data, 32'(seg_tab[k/2]));
        end

        run_to(106);
        check("mid_scan_sel", seg_sel, 32'b1101);
        rst = 1'b1; load = 1'b1; load_data = 16'h5678; ena = 1'b1;
        step();
        check("rst2_count", count, 32'h0000);
        check("rst2_sel", seg_sel, 32'b1110);
        check("rst2_seg", seg_data, 32'b1000000);
        check("rst2_tick", tick, 0);
        check("rst2_tc", tc, 0);
        rst = 1'b0; load = 1'b0; ena = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            step();
            check("tick_after_rst", tick, 32'(c == 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/contador_bcd_param.md
CONTADOR_BCD_PARAM -- requirements
Module: contador_bcd_param

Interface
REQ-001 SHALL: parameter NUM_DIGITS, default 4, number of BCD digits (legal 1..8).
REQ-002 SHALL: parameter TICK_DIV, default 50000000, clk cycles per count tick (legal >=2).
REQ-003 SHALL: parameter SCAN_DIV, default 50000, clk cycles each display digit stays selected (legal >=1).
REQ-004 SHALL: clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL: rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL: ena  input  1  count enable, sampled only on tick cycles.
REQ-007 SHALL: up_dn  input  1  direction; 1 = up, 0 = down.
REQ-008 SHALL: load  input  1  synchronous load strobe.
REQ-009 SHALL: load_data  input  4*NUM_DIGITS  BCD load value, digit 0 in bits [3:0].
REQ-010 SHALL: count  output  4*NUM_DIGITS  registered BCD count, digit 0 least significant.
REQ-011 SHALL: tick  output  1  registered prescaler pulse.
REQ-012 SHALL: tc  output  1  registered terminal-count pulse on wrap.
REQ-013 SHALL: seg_sel  output  NUM_DIGITS  registered one-hot active-low digit select.
REQ-014 SHALL: seg_data  output  7  registered active-low segments, order gfedcba.

Function
REQ-015 SHALL: prescaler counts 0..TICK_DIV-1 and wraps to 0; tick is high for exactly the one cycle after the prescaler reaches TICK_DIV-1, period TICK_DIV.
REQ-016 SHALL: prescaler runs free, independent of ena, load and up_dn.
REQ-017 SHALL: count changes only on a cycle with tick=1 and ena=1, otherwise holds, except for load.
REQ-018 SHALL: up step increments digit 0; a digit at 9 becomes 0 and carries into the next digit; ripple completes in one clk.
REQ-019 SHALL: down step decrements digit 0; a digit at 0 becomes 9 and borrows from the next digit.
REQ-020 SHALL: wrap up (all 9 -> all 0) or down (all 0 -> all 9) asserts tc for exactly one cycle, coincident with the new count value; tc is 0 otherwise.
REQ-021 SHALL: load=1 writes load_data to count on the next edge, regardless of tick/ena; any nibble >9 is stored as 0.
REQ-022 SHALL: load coinciding with a counting tick takes priority; no step occurs and tc stays 0.
REQ-023 SHALL: up_dn change takes effect on the next counting tick, with no glitch step.
REQ-024 SHALL: scan counter advances digit index 0,1,..,NUM_DIGITS-1,0 every SCAN_DIV cycles.
REQ-025 SHALL: seg_sel bit i is low only while index = i.
REQ-026 SHALL: seg_data is the decode of the selected digit of count, updated in the same edge as seg_sel.
REQ-027 SHALL: decode, active-low gfedcba: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010 7=1111000 8=0000000 9=0010000.
REQ-028 SHALL: seg_data follows count changes within one clk while the index is unchanged.

Reset
REQ-029 SHALL: rst=1 at an edge forces count=0, prescaler=0, tick=0, tc=0, scan index=0, seg_sel=all ones except bit0=0, seg_data=1000000.
REQ-030 SHALL: rst overrides load, ena and a pending tick; mid-count reset loses the partial prescaler period, and the first tick follows TICK_DIV cycles after rst deasserts.
REQ-031 SHALL: no output is X after the first edge with rst=1.

Verification (TICK_DIV=4, SCAN_DIV=2, NUM_DIGITS=4)
REQ-032 SHALL: rst high 3 cycles -> count=0x0000, tc=0, tick=0, seg_sel=1110, seg_data=1000000; first tick 4 cycles after release.
REQ-033 SHALL: ena=1, up_dn=1 from reset for 10 ticks (40 cycles) -> count=0x0010; ena=0 for 5 ticks -> count holds 0x0010 while tick keeps pulsing.
REQ-034 SHALL: load 0x9999, up, ena=1 -> next tick count=0x0000 with tc high one cycle; following tick 0x0001 with tc=0.
REQ-035 SHALL: load 0x0000, up_dn=0, ena=1 -> next tick 0x9999 with tc pulse; next tick 0x9998.
REQ-036 SHALL: load 0x12A4 asserted in the same cycle as a counting tick -> count=0x1204, tc=0, no step.
REQ-037 SHALL: load 0x1234, ena=0 -> seg_sel cycles 1110,1101,1011,0111, 2 cycles each, with seg_data 0011001,0110000,0100100,1111001; rst mid-scan returns to 1110/1000000 on the next edge.
